module_3: RTL and testbench
===========================

MODULE_3 -- requirements
Module: module_3

Interface
REQ-001 Parameter TRIP_COUNT, default 5, SHALL set the number of elements produced per invocation.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width of the memory and both FIFOs.
REQ-003 Parameter ADDR_W, default 3, SHALL set the width of the memory address and of the loop counter.
REQ-004 ap_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 ap_rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 ap_start  in  1  SHALL be the invocation request.
REQ-007 ap_done  out  1  SHALL be the completion flag, held until ap_continue.
REQ-008 ap_continue  in  1  SHALL clear the held completion flag.
REQ-009 ap_idle  out  1  SHALL be high in IDLE while ap_start is low.
REQ-010 ap_ready  out  1  SHALL be a one-cycle pulse meaning a new ap_start is accepted.
REQ-011 A_address0  out  ADDR_W  SHALL be the source memory read address.
REQ-012 A_ce0  out  1  SHALL be the source memory read enable.
REQ-013 A_q0  in  DATA_W  SHALL be the source memory read data, valid one cycle after A_ce0.
REQ-014 D_din  out  DATA_W; D_full_n  in  1; D_write  out  1  SHALL form the FIFO D write port.
REQ-015 E_din  out  DATA_W; E_full_n  in  1; E_write  out  1  SHALL form the FIFO E write port.

Function
REQ-016 FSM SHALL be one-hot with three states: IDLE, RD, WR.
REQ-017 IDLE->RD SHALL occur when ap_start=1 and done_reg=0; this transition SHALL clear counter i to 0.
REQ-018 RD with i<TRIP_COUNT SHALL assert A_ce0=1 with A_address0=i, then go to WR.
REQ-019 RD with i==TRIP_COUNT SHALL pulse ap_done=1 and ap_ready=1 for one cycle, set done_reg, return to IDLE, and issue no memory access.
REQ-020 WR SHALL drive D_din=A_q0 and E_din=(A_q0<<1) truncated to DATA_W bits; overflow wraps.
REQ-021 WR SHALL assert D_write and E_write together only in a cycle where D_full_n=1 and E_full_n=1; on that cycle i SHALL increment by 1 and the FSM SHALL go to RD.
REQ-022 WR with either full_n low SHALL stall with both writes low, i unchanged, A_ce0 low, so A_q0 stays stable; a partial write (one FIFO only) SHALL never occur.
REQ-023 Minimum per-element latency SHALL be 2 cycles (RD+WR); one invocation with no stalls SHALL take 2*TRIP_COUNT+1 cycles from the start-accept edge to the ap_done pulse.
REQ-024 ap_done SHALL equal (done pulse) OR done_reg; done_reg SHALL clear on any cycle with ap_continue=1, and ap_continue SHALL take priority over a simultaneous set.
REQ-025 ap_start while done_reg=1 SHALL be ignored; the FSM stays in IDLE.
REQ-026 A_ce0, D_write and E_write SHALL be 0 in every state other than those stated above.

Reset
REQ-027 ap_rst_n=0 SHALL asynchronously force FSM=IDLE, i=0 and done_reg=0.
REQ-028 While in reset: ap_done, ap_ready, A_ce0, D_write and E_write SHALL be 0, and ap_idle SHALL follow ap_start inverted.
REQ-029 Reset asserted mid-invocation SHALL abandon the invocation; no FIFO write SHALL occur after reset assertion, and elements already written are not retracted.

Structure
REQ-030 State encodings, TRIP_COUNT, DATA_W and ADDR_W defaults SHALL reside in a shared package used by module_3 and its consumer module.
REQ-031 The block SHALL be a single module with no sub-modules; the FIFOs and memory SHALL be external.

Verification
REQ-032 A={1,2,3,4,5}, both full_n=1, ap_start pulse -> D receives 1,2,3,4,5; E receives 2,4,6,8,10; ap_done pulses 11 cycles after start accept.
REQ-033 E_full_n=0 for 3 cycles during element 2 -> no D write during the stall, D and E counts stay equal, A_q0 is held, and the sequence completes correctly.
REQ-034 A[0]=0x80000001 -> E_din=0x00000002 (wrap), D_din=0x80000001.
REQ-035 ap_continue held 0 after done, ap_start=1 -> FSM stays in IDLE with ap_done=1; ap_continue=1 -> next cycle ap_done=0 and a new start is accepted.
REQ-036 ap_rst_n dropped in WR of element 3 -> writes drop to 0 immediately; after release, ap_idle=1 and a fresh run produces all 5 elements from index 0.

Source files
------------

// File: rtl/module_3_pkg.sv
// rtl/module_3_pkg.sv - shared state encoding and default geometry for module_3 and its consumers
package module_3_pkg;

  localparam int DEF_TRIP_COUNT = 5;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RD   = 3'b010,
    S_WR   = 3'b100
  } state_t;

endpackage

// File: rtl/module_3.sv
// rtl/module_3.sv - reads TRIP_COUNT words from memory A, writes x to FIFO D and x<<1 to FIFO E
module module_3
  import module_3_pkg::*;
#(
  parameter int TRIP_COUNT = DEF_TRIP_COUNT,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] A_address0,
  output logic              A_ce0,
  input  logic [DATA_W-1:0] A_q0,
  output logic [DATA_W-1:0] D_din,
  input  logic              D_full_n,
  output logic              D_write,
  output logic [DATA_W-1:0] E_din,
  input  logic              E_full_n,
  output logic              E_write
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TRIP_COUNT);

  state_t            state;
  logic [ADDR_W-1:0] i;
  logic              done_reg;

  logic in_idle, in_rd, in_wr, at_end, fifo_ok;

  assign in_idle = (state == S_IDLE);
  assign in_rd   = (state == S_RD);
  assign in_wr   = (state == S_WR);
  assign at_end  = in_rd && (i == LAST);
  // Both FIFOs must have room, otherwise neither is written.
  assign fifo_ok = D_full_n && E_full_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= S_IDLE;
      i        <= '0;
      done_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ap_start && !done_reg) begin
          state <= S_RD;
          i     <= '0;
        end
        S_RD:   state <= at_end ? S_IDLE : S_WR;
        S_WR:   if (fifo_ok) begin
          i     <= i + 1'b1;
          state <= S_RD;
        end
        default: state <= S_IDLE;
      endcase
      // ap_continue wins over a done pulse landing in the same cycle.
      if (ap_continue)
        done_reg <= 1'b0;
      else if (at_end)
        done_reg <= 1'b1;
    end
  end

  assign ap_done    = at_end || done_reg;
  assign ap_ready   = at_end;
  assign ap_idle    = in_idle && !ap_start;
  assign A_address0 = i;
  assign A_ce0      = in_rd && !at_end;
  assign D_din      = A_q0;
  assign E_din      = {A_q0[DATA_W-2:0], 1'b0};
  assign D_write    = in_wr && fifo_ok;
  assign E_write    = in_wr && fifo_ok;

endmodule

// File: tb/tb_module_3.sv
// tb/tb_module_3.sv - randomized self-checking bench for module_3 with a queue-based reference model
module tb_module_3;
  import module_3_pkg::*;

  localparam int TC = DEF_TRIP_COUNT;
  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n, ap_start, ap_continue;
  logic          ap_done, ap_idle, ap_ready;
  logic [AW-1:0] A_address0;
  logic          A_ce0;
  logic [DW-1:0] A_q0;
  logic [DW-1:0] D_din, E_din;
  logic          D_full_n, E_full_n, D_write, E_write;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] eq[$];

  always #5 ap_clk = ~ap_clk;

  module_3 dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .A_address0(A_address0), .A_ce0(A_ce0), .A_q0(A_q0),
    .D_din(D_din), .D_full_n(D_full_n), .D_write(D_write),
    .E_din(E_din), .E_full_n(E_full_n), .E_write(E_write)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // External single-port memory with one-cycle read latency.
  always @(posedge ap_clk) if (A_ce0) A_q0 <= mem[A_address0];

  // FIFO capture plus write-protocol checks.
  always @(posedge ap_clk) begin
    if (D_write || E_write) begin
      check("write_pair", {62'd0, D_write, E_write}, 64'd3);
      check("write_room", {62'd0, D_full_n, E_full_n}, 64'd3);
    end
    if (D_write) dq.push_back(D_din);
    if (E_write) eq.push_back(E_din);
  end

  function automatic logic [DW-1:0] ref_e(input logic [DW-1:0] a);
    longint unsigned v;
    v = (longint'(a) * 2) % (64'd1 << DW);
    return v[DW-1:0];
  endfunction

  task automatic compare_fifos();
    check("d_count", dq.size(), TC);
    check("e_count", eq.size(), TC);
    for (int k = 0; k < TC && k < dq.size() && k < eq.size(); k++) begin
      check($sformatf("d_data[%0d]", k), dq[k], mem[k]);
      check($sformatf("e_data[%0d]", k), eq[k], ref_e(mem[k]));
    end
  endtask

  // Starts an invocation from a negedge with done cleared; returns at the negedge showing ap_done.
  task automatic run(input bit rnd, input bit chk_lat, input int stall_idx);
    int cyc;
    bit done_seen;
    logic [DW-1:0] held;
    dq.delete();
    eq.delete();
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    cyc = 1;
    done_seen = 1'b0;
    while (!done_seen && cyc < 300) begin
      if (ap_done) begin
        done_seen = 1'b1;
      end else if (stall_idx >= 0 && A_ce0 && A_address0 == AW'(stall_idx)) begin
        E_full_n = 1'b0;
        @(negedge ap_clk);
        cyc++;
        held = A_q0;
        for (int k = 0; k < 3; k++) begin
          check("stall_d_write", D_write, 0);
          check("stall_a_ce0", A_ce0, 0);
          check("stall_a_q0", A_q0, held);
          check("stall_counts", dq.size(), eq.size());
          if (k == 2) E_full_n = 1'b1;
          @(negedge ap_clk);
          cyc++;
        end
      end else begin
        if (rnd) begin
          D_full_n = ($urandom_range(0, 3) != 0);
          E_full_n = ($urandom_range(0, 3) != 0);
        end
        @(negedge ap_clk);
        cyc++;
      end
    end
    D_full_n = 1'b1;
    E_full_n = 1'b1;
    check("done_seen", done_seen, 1);
    check("ready_with_done", ap_ready, 1);
    if (chk_lat) check("latency", cyc, 2 * TC + 1);
    compare_fifos();
  endtask

  task automatic ack_done();
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    check("done_cleared", ap_done, 0);
  endtask

  initial begin
    int waitc;
    ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    D_full_n = 1'b1; E_full_n = 1'b1;
    for (int k = 0; k < 2**AW; k++) mem[k] = '0;

    repeat (2) @(negedge ap_clk);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_ce0", A_ce0, 0);
    check("rst_writes", {D_write, E_write}, 0);
    check("rst_idle_start0", ap_idle, 1);
    ap_start = 1'b1;
    #1 check("rst_idle_start1", ap_idle, 0);
    @(negedge ap_clk);
    check("rst_no_run", A_ce0, 0);
    ap_start = 1'b0;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("idle_after_rst", ap_idle, 1);

    // Directed incrementing data, no backpressure.
    for (int k = 0; k < TC; k++) mem[k] = DW'(k + 1);
    run(1'b0, 1'b1, -1);
    ack_done();

    // Shift overflow wraps.
    mem[0] = 32'h8000_0001;
    run(1'b0, 1'b1, -1);
    check("wrap_d0", dq.size() > 0 ? dq[0] : '1, 32'h8000_0001);
    check("wrap_e0", eq.size() > 0 ? eq[0] : '1, 32'h0000_0002);
    ack_done();

    // Three-cycle E stall during the second element.
    for (int k = 0; k < TC; k++) mem[k] = $urandom;
    run(1'b0, 1'b0, 1);

    // Held done blocks restarts until ap_continue.
    @(negedge ap_clk);
    check("done_held", ap_done, 1);
    ap_start = 1'b1;
    repeat (3) begin
      @(negedge ap_clk);
      check("start_ignored_ce0", A_ce0, 0);
      check("start_ignored_done", ap_done, 1);
    end
    ap_start = 1'b0;
    ack_done();
    for (int k = 0; k < TC; k++) mem[k] = $urandom;
    run(1'b0, 1'b1, -1);
    ack_done();

    // Random data with random backpressure on both FIFOs.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < TC; k++) mem[k] = $urandom;
      run(1'b1, 1'b0, -1);
      ack_done();
    end

    // Reset during the write of the third element.
    for (int k = 0; k < TC; k++) mem[k] = $urandom;
    dq.delete();
    eq.delete();
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    waitc = 0;
    while (!(A_ce0 && A_address0 == AW'(2)) && waitc < 50) begin
      @(negedge ap_clk);
      waitc++;
    end
    check("reach_rd2", waitc < 50, 1);
    @(negedge ap_clk);
    check("wr2_active", D_write, 1);
    ap_rst_n = 1'b0;
    #1;
    check("rst_drop_d", D_write, 0);
    check("rst_drop_e", E_write, 0);
    repeat (2) @(negedge ap_clk);
    check("rst_partial_d", dq.size(), 2);
    check("rst_partial_e", eq.size(), 2);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("idle_after_abort", ap_idle, 1);
    check("done_after_abort", ap_done, 0);
    run(1'b0, 1'b1, -1);
    ack_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
